// File: rtl/gf180mcu_fd_sc_mcu7t5v0_clkdiv_gate.sv
// Glitch-free programmable clock divider feeding the clkbuf_8 I pin; ratio reloads only on period boundaries.
// Optional period counter output PCNT when GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0_clkdiv_gate #(
  parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV,
  output logic             Z,
  output logic             ACK,
  output logic             BUSY
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN
  ,
  output logic [15:0]      PCNT
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_pend;
  logic             pend;
  logic             ack;

  logic             at_bound;
  logic             apply_pt;
  logic             apply_new;
  logic [WIDTH-1:0] eff;

  // A new ratio may only land while idle or at the very end of a low phase,
  // so a running high/low pair always shares one ratio.
  always_comb begin
    at_bound  = (state == LOW) && (cnt == '0);
    apply_pt  = (state == IDLE) || at_bound;
    apply_new = apply_pt && (LOAD || pend);
    eff       = div_act;
    if (apply_pt && LOAD)
      eff = DIV;
    else if (apply_pt && pend)
      eff = div_pend;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      div_act  <= '0;
      div_pend <= '0;
      pend     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= apply_new;
      if (LOAD)
        div_pend <= DIV;
      if (apply_new) begin
        div_act <= eff;
        pend    <= 1'b0;
      end else if (LOAD) begin
        pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (EN) begin
            state <= HIGH;
            cnt   <= eff;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state <= LOW;
            cnt   <= div_act;
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
          end else if (EN) begin
            state <= HIGH;
            cnt   <= eff;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign Z    = (state == HIGH);
  assign BUSY = (state != IDLE);
  assign ACK  = ack;

`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN
  logic [15:0] pcnt;

  // Cleared the cycle after a ratio change so the count reflects the current ratio only.
  always_ff @(posedge CLK) begin
    if (RST)
      pcnt <= '0;
    else if (ack)
      pcnt <= '0;
    else if (at_bound && (pcnt != 16'hFFFF))
      pcnt <= pcnt + 16'd1;
  end

  assign PCNT = pcnt;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0_clkdiv_gate.sv
// Self-checking bench for the clock divider: vector table plus long-running ratio, reload and gating sequences.
module tb_gf180mcu_fd_sc_mcu7t5v0_clkdiv_gate;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             LOAD = 1'b0;
  logic [WIDTH-1:0] DIV = '0;
  logic             Z;
  logic             ACK;
  logic             BUSY;
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN
  logic [15:0]      PCNT;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int rst; int en; int ld; int div;
    int z; int ack; int busy;
  } vec_t;

  vec_t       vecs[29];
  logic [2:0] expq[$];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0_clkdiv_gate #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .LOAD(LOAD),
    .DIV (DIV),
    .Z   (Z),
    .ACK (ACK),
    .BUSY(BUSY)
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN
    ,
    .PCNT(PCNT)
`endif
  );

  task automatic step(input logic rst, input logic en, input logic ld,
                      input logic [WIDTH-1:0] d, input logic ez, input logic ea,
                      input logic eb, input string tag);
    logic [2:0] exp;
    logic [2:0] got;
    RST  = rst;
    EN   = en;
    LOAD = ld;
    DIV  = d;
    expq.push_back({ez, ea, eb});
    @(posedge CLK);
    #1;
    exp = expq.pop_front();
    got = {Z, ACK, BUSY};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s z/ack/busy actual=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic run_ratio(input logic [WIDTH-1:0] d, input int periods, input string tag);
    int half = int'(d) + 1;
    step(1'b1, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, {tag, "_rst"});
    step(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b1, 1'b0, {tag, "_load"});
    for (int i = 0; i < periods * 2 * half; i++)
      step(1'b0, 1'b1, 1'b0, WIDTH'(0), (i % (2 * half)) < half, 1'b0, 1'b1,
           $sformatf("%s_c%0d", tag, i));
    step(1'b0, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, {tag, "_stop"});
  endtask

  initial begin
    // rst en ld div | z ack busy
    vecs[0]  = '{1, 1, 1, 5, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 5, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 0, 1};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 1, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 1, 0, 1};
    vecs[14] = '{0, 1, 0, 0, 1, 0, 1};
    vecs[15] = '{0, 1, 1, 3, 0, 0, 1};
    vecs[16] = '{0, 1, 1, 2, 0, 0, 1};
    vecs[17] = '{0, 1, 0, 0, 1, 1, 1};
    vecs[18] = '{0, 1, 0, 0, 1, 0, 1};
    vecs[19] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[21] = '{0, 1, 1, 1, 1, 1, 1};
    vecs[22] = '{0, 1, 0, 0, 1, 0, 1};
    vecs[23] = '{0, 1, 0, 0, 0, 0, 1};
    vecs[24] = '{0, 1, 0, 0, 0, 0, 1};
    vecs[25] = '{0, 1, 1, 0, 1, 1, 1};
    vecs[26] = '{0, 1, 0, 0, 0, 0, 1};
    vecs[27] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[28] = '{0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 29; i++)
      step(1'(vecs[i].rst), 1'(vecs[i].en), 1'(vecs[i].ld), WIDTH'(vecs[i].div),
           1'(vecs[i].z), 1'(vecs[i].ack), 1'(vecs[i].busy), $sformatf("vec%0d", i));

    run_ratio(WIDTH'(2), 10, "div2");
    run_ratio(WIDTH'(0), 5, "div0");
    run_ratio(WIDTH'(255), 2, "div255");

    // Reload mid-period: LOAD 1 in HIGH, LOAD 5 in LOW; one ACK at the boundary, then 6/6.
    step(1'b1, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, "reload_rst");
    step(1'b0, 1'b0, 1'b1, WIDTH'(3), 1'b0, 1'b1, 1'b0, "reload_load3");
    for (int i = 0; i < 20; i++) begin
      logic ld;
      logic [WIDTH-1:0] d;
      ld = (i == 1) || (i == 5);
      d  = (i == 1) ? WIDTH'(1) : WIDTH'(5);
      step(1'b0, 1'b1, ld, d, (i < 4) || (i >= 8 && i < 14), i == 8, 1'b1,
           $sformatf("reload_c%0d", i));
    end
    step(1'b0, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, "reload_stop");

    // Gating: EN dropped in the second high cycle of a 4/4 period.
    step(1'b1, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, "gate_rst");
    step(1'b0, 1'b0, 1'b1, WIDTH'(3), 1'b0, 1'b1, 1'b0, "gate_load3");
    for (int i = 0; i < 10; i++)
      step(1'b0, i == 0, 1'b0, WIDTH'(0), i < 4, 1'b0, i < 8, $sformatf("gate_c%0d", i));

`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_PCNT_EN
    run_ratio(WIDTH'(1), 5, "pcnt");
    checks++;
    if (PCNT !== 16'd5) begin
      failures++;
      $display("FAIL pcnt_count actual=%0d required=5", PCNT);
    end
    step(1'b0, 1'b0, 1'b1, WIDTH'(2), 1'b0, 1'b1, 1'b0, "pcnt_load");
    step(1'b0, 1'b0, 1'b0, WIDTH'(0), 1'b0, 1'b0, 1'b0, "pcnt_after_ack");
    checks++;
    if (PCNT !== 16'd0) begin
      failures++;
      $display("FAIL pcnt_clear actual=%0d required=0", PCNT);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
